// File: rtl/lcd_pkg.sv
// Shared LCD definitions: FSM encodings, 50 MHz timing defaults and command codes.
// Used by the init controller and the byte writer.
package lcd_pkg;

  localparam int unsigned CNT_W = 20;

  localparam int unsigned SETUP_CYCLES_DEF      = 2;
  localparam int unsigned PULSE_CYCLES_DEF      = 12;
  localparam int unsigned HOLD_CYCLES_DEF       = 1;
  localparam int unsigned NIBBLE_GAP_CYCLES_DEF = 50;
  localparam int unsigned BYTE_WAIT_CYCLES_DEF  = 2000;
  localparam int unsigned LONG_WAIT_CYCLES_DEF  = 82000;
  localparam int unsigned INIT_WAIT_15MS_CYCLES = 750000;
  localparam int unsigned INIT_WAIT_4MS_CYCLES  = 205000;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HI, ST_GAP, ST_LO, ST_WAIT
  } byte_state_t;

  typedef enum logic [1:0] {
    NS_IDLE, NS_SETUP, NS_PULSE, NS_HOLD
  } nib_state_t;

  function automatic logic is_long_cmd(input logic [7:0] b, input logic rs);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// One nibble write: setup, E pulse, hold; done_o is high in the final hold cycle.
// Nibble is captured on start_i; start_i is only honoured while idle.
module lcd_nibble_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] nibble_i,
  output logic       done_o,
  output logic       en_o,
  output logic [3:0] data_o
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  nib_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [3:0]       data_q, data_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= NS_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    done_o  = 1'b0;
    case (state_q)
      NS_IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = NS_SETUP;
      end
      NS_SETUP: if (cnt_q == SETUP_LAST) begin
        state_d = NS_PULSE;
        cnt_d   = '0;
      end
      NS_PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = NS_HOLD;
        cnt_d   = '0;
      end
      NS_HOLD: if (cnt_q == HOLD_LAST) begin
        state_d = NS_IDLE;
        cnt_d   = '0;
        done_o  = 1'b1;
      end
      default: begin
        state_d = NS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Data is frozen for the whole sequence so it cannot move under E.
  always_comb begin
    en_d   = (state_d == NS_PULSE);
    data_d = (state_d == NS_IDLE) ? 4'h0 :
             (state_q == NS_IDLE) ? nibble_i : data_q;
  end

  assign en_o   = en_q;
  assign data_o = data_q;

endmodule

// File: rtl/lcd_byte_writer.sv
// 4-bit LCD byte writer: high nibble, gap, low nibble, execution wait; oDone with oReady after wait.
// One byte in flight, inputs ignored while busy. LCD_LONG_CMD_WAIT_EN stretches clear/home waits.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES      = SETUP_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES      = PULSE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES       = HOLD_CYCLES_DEF,
  parameter int unsigned NIBBLE_GAP_CYCLES = NIBBLE_GAP_CYCLES_DEF,
  parameter int unsigned BYTE_WAIT_CYCLES  = BYTE_WAIT_CYCLES_DEF,
  parameter int unsigned LONG_WAIT_CYCLES  = LONG_WAIT_CYCLES_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iByte,
  input  logic       iRegisterSelect,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic [3:0] oLCD_Data
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(NIBBLE_GAP_CYCLES - 1);

  byte_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wait_last;
  logic [3:0]       lo_q, lo_d;
  logic             rs_q, rs_d, long_q, long_d;
  logic             ready_q, ready_d, done_q, done_d, lcd_rs_q, lcd_rs_d;
  logic             accept, strobe_start, strobe_done;
  logic [3:0]       strobe_nibble;

  assign accept = iValid && ready_q;

`ifdef LCD_LONG_CMD_WAIT_EN
  assign long_d = accept ? is_long_cmd(iByte, iRegisterSelect) : long_q;
`else
  assign long_d = 1'b0;
`endif

  assign wait_last = long_q ? CNT_W'(LONG_WAIT_CYCLES - 1) : CNT_W'(BYTE_WAIT_CYCLES - 1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lo_q     <= 4'h0;
      rs_q     <= 1'b0;
      long_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      lcd_rs_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      rs_q     <= rs_d;
      long_q   <= long_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      lcd_rs_q <= lcd_rs_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    strobe_start = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d      = ST_HI;
        strobe_start = 1'b1;
      end
      ST_HI: if (strobe_done) state_d = ST_GAP;
      ST_GAP: if (cnt_q == GAP_LAST) begin
        state_d      = ST_LO;
        strobe_start = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_LO: if (strobe_done) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == wait_last) state_d = ST_IDLE;
               else cnt_d = cnt_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  // High nibble goes straight from the input at accept; only the low nibble needs storing.
  always_comb begin
    lo_d          = accept ? iByte[3:0] : lo_q;
    rs_d          = accept ? iRegisterSelect : rs_q;
    ready_d       = (state_d == ST_IDLE);
    done_d        = (state_q == ST_WAIT) && (state_d == ST_IDLE);
    lcd_rs_d      = (state_d != ST_IDLE) && rs_d;
    strobe_nibble = (state_q == ST_IDLE) ? iByte[7:4] : lo_q;
  end

  lcd_nibble_strobe #(
    .SETUP_CYCLES(SETUP_CYCLES),
    .PULSE_CYCLES(PULSE_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_strobe (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .start_i (strobe_start),
    .nibble_i(strobe_nibble),
    .done_o  (strobe_done),
    .en_o    (oLCD_Enabled),
    .data_o  (oLCD_Data)
  );

  assign oReady              = ready_q;
  assign oDone               = done_q;
  assign oLCD_RegisterSelect = lcd_rs_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer against a timeline model of each byte write.
module tb_lcd_byte_writer;

  localparam int S = 2, P = 12, H = 1, G = 50, W = 2000, LW = 82000;
  localparam int NIB = S + P + H;
`ifdef LCD_LONG_CMD_WAIT_EN
  localparam int LONG_DONE = 81 + 82000;
`else
  localparam int LONG_DONE = 2081;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] iByte;
  logic       iRegisterSelect, iValid;
  logic       oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect;
  logic [3:0] oLCD_Data;

  lcd_byte_writer dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .iByte              (iByte),
    .iRegisterSelect    (iRegisterSelect),
    .iValid             (iValid),
    .oReady             (oReady),
    .oDone              (oDone),
    .oLCD_Enabled       (oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_Data          (oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int checks = 0, errors = 0;
  int n = 0;
  bit m_busy = 0, m_done = 0;
  int m_t0 = 0, m_tot = 0;
  logic [7:0] m_byte = 8'h00;
  logic m_rs = 1'b0;
  int e_first[$], e_last[$], done_at[$];
  logic [3:0] e_dat[$];

  function automatic int wait_for(input logic [7:0] b, input logic rs);
`ifdef LCD_LONG_CMD_WAIT_EN
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return LW;
`endif
    return W;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rs, output int t0);
    int g;
    g = 0;
    iValid = 1'b1; iByte = b; iRegisterSelect = rs;
    do begin @(posedge Clock); #1; g++; end
    while (!(m_busy && m_t0 == n) && g < 5000);
    check("accept", int'(m_busy && m_t0 == n), 1);
    t0 = m_t0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_busy && g < 100000) begin @(posedge Clock); #1; g++; end
    check("ready_after_write", int'(oReady), 1);
  endtask

  task automatic clear_obs();
    e_first.delete(); e_last.delete(); e_dat.delete(); done_at.delete();
  endtask

  initial begin
    int t0, t1, t2, k;
    logic [7:0] rb;
    logic rrs;
    Reset = 1'b1; iValid = 1'b0; iByte = 8'h00; iRegisterSelect = 1'b0;

    fork
      // Reference timeline: what each byte's write must look like cycle by cycle.
      forever begin
        @(posedge Clock);
        n++;
        if (Reset) begin
          m_busy = 0; m_done = 0;
        end else if (!m_busy && iValid) begin
          m_busy = 1; m_done = 0; m_t0 = n; m_byte = iByte; m_rs = iRegisterSelect;
          m_tot = 2 * NIB + G + wait_for(iByte, iRegisterSelect);
        end else if (m_busy && n == m_t0 + m_tot) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_done = 0;
        end
      end
      forever begin : cmp
        int kk, lo_k;
        logic [3:0] ed;
        logic ee, ers;
        logic pe;
        logic [3:0] pd;
        logic prs;
        pe = 0; pd = 0; prs = 0;
        forever begin
          @(negedge Clock);
          if (!Reset) begin
            ed = 4'h0; ee = 1'b0; ers = 1'b0;
            if (m_busy) begin
              kk = n - m_t0 + 1;
              lo_k = kk - (NIB + G);
              ers = m_rs;
              if (kk <= NIB) begin
                ed = m_byte[7:4]; ee = (kk > S && kk <= S + P);
              end else if (lo_k >= 1 && lo_k <= NIB) begin
                ed = m_byte[3:0]; ee = (lo_k > S && lo_k <= S + P);
              end
            end
            check("outputs{rdy,done,E,RS,DB}",
                  int'({oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data}),
                  int'({!m_busy, m_done && !m_busy, ee, ers, ed}));
            if (oLCD_Enabled && pe)
              check("stable_under_E", int'({oLCD_RegisterSelect, oLCD_Data}), int'({prs, pd}));
            if (oLCD_Enabled && !pe) begin e_first.push_back(n); e_dat.push_back(oLCD_Data); end
            if (!oLCD_Enabled && pe) e_last.push_back(n - 1);
            if (oDone) done_at.push_back(n);
          end
          pe = oLCD_Enabled && !Reset; pd = oLCD_Data; prs = oLCD_RegisterSelect;
        end
      end
    join_none

    @(negedge Clock);
    check("reset_values", int'({oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data}), 8'h80);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat ($urandom_range(1, 6)) @(posedge Clock);
    #1;

    // Data byte 0x48 with junk on the inputs while busy and 0xFF parked on iByte in GAP.
    clear_obs();
    send(8'h48, 1'b1, t0);
    k = n - t0 + 1;
    while (k < 2070) begin
      if (k >= 16 && k <= 65) begin
        iValid = 1'b1; iByte = 8'hFF; iRegisterSelect = 1'b0;
      end else begin
        iValid = 1'($urandom_range(0, 1)); iByte = 8'($urandom); iRegisterSelect = 1'($urandom_range(0, 1));
      end
      @(posedge Clock); #1;
      k = n - t0 + 1;
    end
    iValid = 1'b0;
    wait_idle();
    @(posedge Clock); #1;
    check("hi_E_first", e_first[0] - t0 + 1, 3);
    check("hi_E_last", e_last[0] - t0 + 1, 14);
    check("hi_DB", int'(e_dat[0]), 4'h4);
    check("lo_E_first", e_first[1] - t0 + 1, 68);
    check("lo_E_last", e_last[1] - t0 + 1, 79);
    check("lo_DB_after_ignore", int'(e_dat[1]), 4'h8);
    check("done_cycle_0x48", done_at[0] - t0 + 1, 2081);

    // Back-to-back commands with iValid held.
    clear_obs();
    send(8'h28, 1'b0, t1);
    send(8'h0C, 1'b0, t2);
    iValid = 1'b0;
    check("b2b_accept_in_done_cycle", t2 - done_at[0], 1);
    wait_idle();
    @(posedge Clock); #1;
    check("b2b_second_done", done_at[1] - t2 + 1, 2081);

    // One random byte, kept away from the long-wait commands.
    clear_obs();
    rb = 8'($urandom); rrs = 1'($urandom_range(0, 1));
    if (!rrs && rb < 8'h04) rb = rb | 8'h40;
    repeat ($urandom_range(0, 5)) @(posedge Clock);
    #1;
    send(rb, rrs, t0);
    iValid = 1'b0;
    wait_idle();
    @(posedge Clock); #1;
    check("rand_hi_DB", int'(e_dat[0]), int'(rb[7:4]));
    check("rand_lo_DB", int'(e_dat[1]), int'(rb[3:0]));
    check("rand_done_cycle", done_at[0] - t0 + 1, 2081);

    // Clear command: wait length depends on the build.
    clear_obs();
    send(8'h01, 1'b0, t0);
    iValid = 1'b0;
    wait_idle();
    @(posedge Clock); #1;
    check("clear_done_cycle", done_at[0] - t0 + 1, LONG_DONE);

    // Reset in the middle of the high-nibble E pulse.
    clear_obs();
    send(8'h35, 1'b1, t0);
    iValid = 1'b0;
    repeat (6) @(posedge Clock);
    #2;
    check("E_before_reset", int'(oLCD_Enabled), 1);
    Reset = 1'b1;
    #1;
    check("reset_async_outputs", int'({oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data}), 8'h80);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_held_outputs", int'({oReady, oDone, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data}), 8'h80);
    @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (100) @(posedge Clock);
    #1;
    check("ready_after_reset", int'(oReady), 1);
    check("no_done_after_reset", done_at.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
